// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and controller state enum,
// used by the multicycle ALU and the surrounding controller.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_ADDU = 4'd2,
        OP_SUB  = 4'd3,
        OP_SUBU = 4'd4,
        OP_XOR  = 4'd5,
        OP_OR   = 4'd6,
        OP_AND  = 4'd7,
        OP_NOR  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLL  = 4'd10,
        OP_SRL  = 4'd11,
        OP_MULT = 4'd12,
        OP_DIV  = 4'd13,
        OP_SRA  = 4'd14
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL,
        DIV,
        DONE
    } alu_state_e;

    function automatic logic isMultiCycle(input alu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) and restoring divide, one bit per cycle,
// operating on magnitudes with sign correction applied to the outputs.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_isDiv,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             r_active;
    logic [CW-1:0]    r_count;
    logic             r_isDiv;
    logic             r_negLo;
    logic             r_negHi;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mag;

    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodSigned;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_absA = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_absB = i_b[WIDTH-1] ? -i_b : i_b;

    // r_hi is the accumulator for multiply and the partial remainder for divide;
    // r_lo shifts out multiplier bits or shifts in quotient bits.
    assign w_mulSum = r_hi + (r_lo[0] ? {1'b0, r_mag} : '0);
    assign w_shift  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_trial  = {1'b0, w_shift} - {2'b00, r_mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_isDiv  <= 1'b0;
            r_negLo  <= 1'b0;
            r_negHi  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mag    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_count  <= '0;
            r_isDiv  <= i_isDiv;
            r_negLo  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_negHi  <= i_isDiv ? i_a[WIDTH-1] : (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_hi     <= '0;
            r_lo     <= i_isDiv ? w_absA : w_absB;
            r_mag    <= i_isDiv ? w_absB : w_absA;
        end else if (r_active) begin
            if (o_done) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count + CW'(1);
                if (r_isDiv) begin
                    r_hi <= w_trial[WIDTH+1] ? w_shift : w_trial[WIDTH:0];
                    r_lo <= {r_lo[WIDTH-2:0], ~w_trial[WIDTH+1]};
                end else begin
                    r_hi <= {1'b0, w_mulSum[WIDTH:1]};
                    r_lo <= {w_mulSum[0], r_lo[WIDTH-1:1]};
                end
            end
        end
    end

    assign o_done       = r_active && (r_count == CW'(WIDTH));
    assign w_prod       = {r_hi[WIDTH-1:0], r_lo};
    assign w_prodSigned = r_negLo ? -w_prod : w_prod;
    assign w_quot       = r_negLo ? -r_lo : r_lo;
    assign w_rem        = r_negHi ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];
    assign o_hi         = r_isDiv ? w_rem  : w_prodSigned[2*WIDTH-1:WIDTH];
    assign o_lo         = r_isDiv ? w_quot : w_prodSigned[WIDTH-1:0];

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ops through EXEC, MULT/DIV through the iterative
// muldiv_unit, with HI/LO registers and status flags updated on completion.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    alu_state_e       r_state;
    alu_state_e       w_nextState;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_zero;
    logic             r_overflow;
    logic             r_divByZero;

    alu_op_e          w_op;
    logic             w_accept;
    logic             w_mdStart;
    logic             w_mdDone;
    logic [WIDTH-1:0] w_mdHi;
    logic [WIDTH-1:0] w_mdLo;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_aluOverflow;
    logic             w_aluValid;
    logic             w_bIsZero;

    assign w_op      = alu_op_e'(alu_operation);
    assign w_accept  = (r_state == IDLE) && start;
    assign w_mdStart = w_accept && ((w_op == OP_MULT) || ((w_op == OP_DIV) && (b != '0)));
    assign w_bIsZero = (r_b == '0);

    muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mdStart),
        .i_isDiv (w_op == OP_DIV),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_mdDone),
        .o_hi    (w_mdHi),
        .o_lo    (w_mdLo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (!isMultiCycle(w_op)) begin
                        w_nextState = EXEC;
                    end else if (w_op == OP_MULT) begin
                        w_nextState = MUL;
                    end else begin
                        w_nextState = DIV;
                    end
                end
            end
            EXEC: w_nextState = DONE;
            MUL:  if (w_mdDone) w_nextState = DONE;
            DIV:  if (w_bIsZero || w_mdDone) w_nextState = DONE;
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_sum   = r_a + r_b;
    assign w_diff  = r_a - r_b;
    assign w_shamt = r_b[4:0];

    // NOP, unused codes and the multicycle codes fall to the default: zero result, no flags.
    always_comb begin
        w_aluResult   = '0;
        w_aluOverflow = 1'b0;
        w_aluValid    = 1'b1;
        case (r_op)
            OP_ADD: begin
                w_aluResult   = w_sum;
                w_aluOverflow = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_ADDU: w_aluResult = w_sum;
            OP_SUB: begin
                w_aluResult   = w_diff;
                w_aluOverflow = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUBU: w_aluResult = w_diff;
            OP_XOR:  w_aluResult = r_a ^ r_b;
            OP_OR:   w_aluResult = r_a | r_b;
            OP_AND:  w_aluResult = r_a & r_b;
            OP_NOR:  w_aluResult = ~(r_a | r_b);
            OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_SLL:  w_aluResult = r_a << w_shamt;
            OP_SRL:  w_aluResult = r_a >> w_shamt;
            OP_SRA:  w_aluResult = $signed(r_a) >>> w_shamt;
            default: w_aluValid  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= OP_NOP;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_divByZero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= w_op;
                r_a  <= a;
                r_b  <= b;
            end
            case (r_state)
                EXEC: begin
                    r_result    <= w_aluResult;
                    r_zero      <= w_aluValid && (w_aluResult == '0);
                    r_overflow  <= w_aluOverflow;
                    r_divByZero <= 1'b0;
                end
                MUL, DIV: begin
                    // A zero divisor never starts the unit, so HI/LO/result stay as they were.
                    if ((r_state == DIV) && w_bIsZero) begin
                        r_zero      <= (r_result == '0);
                        r_overflow  <= 1'b0;
                        r_divByZero <= 1'b1;
                    end else if (w_mdDone) begin
                        r_hi        <= w_mdHi;
                        r_lo        <= w_mdLo;
                        r_result    <= w_mdLo;
                        r_zero      <= (w_mdLo == '0);
                        r_overflow  <= 1'b0;
                        r_divByZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result      = r_result;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign zero        = r_zero;
    assign overflow    = r_overflow;
    assign div_by_zero = r_divByZero;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL expose port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL expose port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL expose port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL expose port alu_operation  input  4  operation code per shared alu_pkg encoding (NOP=0 ... SRA=14).
REQ-006 SHALL expose port a  input  WIDTH  operand A (rs).
REQ-007 SHALL expose port b  input  WIDTH  operand B (rt/immediate); shift amount is b[4:0].
REQ-008 SHALL expose port busy  output  1  high while an accepted operation is in progress.
REQ-009 SHALL expose port done  output  1  one-cycle pulse when result and flags are valid.
REQ-010 SHALL expose port result  output  WIDTH  registered result, held until the next done.
REQ-011 SHALL expose port hi  output  WIDTH  HI register (MULT upper half / DIV remainder).
REQ-012 SHALL expose port lo  output  WIDTH  LO register (MULT lower half / DIV quotient).
REQ-013 SHALL expose ports zero, overflow, div_by_zero  output  1 each  status flags, updated with done.

Function
REQ-014 SHALL latch a, b and alu_operation on the cycle start=1 and busy=0; operands may change afterwards.
REQ-015 SHALL ignore start while busy=1, with no effect on state or outputs.
REQ-016 SHALL use states IDLE, EXEC, MUL, DIV, DONE: IDLE->EXEC for single-cycle ops, IDLE->MUL/DIV for MULT/DIV, EXEC->DONE, MUL/DIV->DONE after WIDTH iterations, DONE->IDLE.
REQ-017 SHALL assert busy in EXEC, MUL, DIV and DONE; done SHALL be high in DONE only.
REQ-018 SHALL, for single-cycle ops, assert done 2 cycles after the accepting edge; for MULT/DIV, WIDTH+2 cycles after it.
REQ-019 SHALL compute ADD/ADDU/SUB/SUBU modulo 2^WIDTH; overflow=1 only for signed overflow on ADD/SUB, else 0.
REQ-020 SHALL compute XOR, OR, AND, NOR bitwise; SLT as signed compare giving 1 or 0; SLL/SRL logical and SRA arithmetic by b[4:0].
REQ-021 SHALL produce result=0 for NOP and for unused code 15, with all flags 0.
REQ-022 SHALL perform MULT as signed shift-add on operand magnitudes, one bit per cycle, sign-correct at the end, write {hi,lo}, and set result=lo.
REQ-023 SHALL perform DIV as signed restoring division, one bit per cycle: lo=quotient truncated toward zero, hi=remainder with sign of a, result=lo.
REQ-024 SHALL, on DIV with b=0, skip iteration (DIV->DONE next cycle), set div_by_zero=1, and leave hi/lo/result unchanged.
REQ-025 SHALL set zero=1 when the new result equals 0 (used by BEQ/BNE via SUB).
REQ-026 SHALL leave hi/lo unchanged on all operations other than a completed nonzero-divisor MULT/DIV.
REQ-027 SHALL accept a new start in the cycle after done, i.e. in IDLE; back-to-back issue costs no extra bubble beyond REQ-018.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-MUL/DIV, abort the operation and enter IDLE immediately.
REQ-029 SHALL reset busy, done, result, hi, lo, zero, overflow and div_by_zero to 0.
REQ-030 SHALL accept a start on the first clock edge after rst deasserts.

Structure
REQ-031 SHALL take the operation codes and the state enum from shared package alu_pkg, which the ALU controller also uses.
REQ-032 SHALL place the iterative multiply/divide datapath (accumulator, shift registers, iteration counter) in sub-module muldiv_unit, with its own start/done handshake.
REQ-033 SHALL keep single-cycle ops combinational into the result register, with no additional pipeline stage.

Verification
REQ-034 ADD a=0x7FFFFFFF b=1 -> done at +2 cycles, result=0x80000000, overflow=1, zero=0; ADDU with same operands -> overflow=0.
REQ-035 SUB a=5 b=5 -> result=0, zero=1; SLT a=0xFFFFFFFF b=1 -> result=1; SRA a=0x80000000 b=4 -> result=0xF8000000.
REQ-036 MULT a=-3 b=7 -> done at +34 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high throughout; a start pulse mid-operation is ignored.
REQ-037 DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=9 b=0 -> div_by_zero=1, hi/lo retain prior values.
REQ-038 rst asserted 10 cycles into a MULT -> busy=0, hi=lo=0 immediately; a following ADD 2+3 issued right after reset -> result=5.
